// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/redirect inputs and pipeline enable/flush outputs of pipeline_ctrl
interface pipeline_ctrl_if;
  logic enable;
  logic [4:0] rs_id, rt_id;
  logic uses_rt_id;
  logic memread_ex, regwrite_ex;
  logic [4:0] rd_ex;
  logic regwrite_mem;
  logic [4:0] rd_mem;
  logic regwrite_wb;
  logic [4:0] rd_wb;
  logic branch_mem, zero_mem, jump_mem;
  logic pc_en, if_id_en, pipe_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic busy;
  logic [15:0] stall_cnt, flush_cnt;
  modport master (
    output enable, rs_id, rt_id, uses_rt_id, memread_ex, regwrite_ex, rd_ex,
           regwrite_mem, rd_mem, regwrite_wb, rd_wb, branch_mem, zero_mem, jump_mem,
    input  pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
           busy, stall_cnt, flush_cnt
  );
  modport slave (
    input  enable, rs_id, rt_id, uses_rt_id, memread_ex, regwrite_ex, rd_ex,
           regwrite_mem, rd_mem, regwrite_wb, rd_wb, branch_mem, zero_mem, jump_mem,
    output pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush,
           busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for a 5-stage pipeline with stall/flush event counters.
// Define PIPELINE_CTRL_FORWARDING_EN to stall only on load-use hazards.
module pipeline_ctrl (
  input logic clk,
  input logic arst_n,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, STALL, FLUSH} state_t;
  state_t state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic run, active, redirect, hazard, do_stall, do_flush;
  function automatic logic match(input logic [4:0] rs, rt, rd, input logic use_rt);
    return (rs != 5'd0 && rs == rd) || (use_rt && rt != 5'd0 && rt == rd);
  endfunction
  always_comb begin
    redirect = (bus.branch_mem & bus.zero_mem) | bus.jump_mem;
`ifdef PIPELINE_CTRL_FORWARDING_EN
    hazard = bus.memread_ex & bus.regwrite_ex & match(bus.rs_id, bus.rt_id, bus.rd_ex, bus.uses_rt_id);
`else
    hazard = (bus.regwrite_ex & match(bus.rs_id, bus.rt_id, bus.rd_ex, bus.uses_rt_id))
           | (bus.regwrite_mem & match(bus.rs_id, bus.rt_id, bus.rd_mem, bus.uses_rt_id))
           | (bus.regwrite_wb & match(bus.rs_id, bus.rt_id, bus.rd_wb, bus.uses_rt_id));
`endif
    // arst_n gates every output so nothing leaks out while reset is held
    run = bus.enable & arst_n;
    active = run & (state_q == RUN || state_q == STALL);
    do_flush = active & redirect;
    do_stall = active & ~redirect & hazard;
    state_d = !bus.enable ? IDLE :
              (state_q == IDLE || state_q == FLUSH) ? RUN :
              do_flush ? FLUSH : do_stall ? STALL : RUN;
    stall_cnt_d = (do_stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (do_flush && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    bus.pc_en = run & ~do_stall;
    bus.if_id_en = run & ~do_stall;
    bus.pipe_en = run;
    bus.if_id_flush = do_flush | (run & state_q == FLUSH);
    bus.id_ex_flush = do_flush | do_stall;
    bus.ex_mem_flush = do_flush;
    bus.busy = state_q != IDLE;
    bus.stall_cnt = stall_cnt_q;
    bus.flush_cnt = flush_cnt_q;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random checks of pipeline_ctrl against a rule-level model.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  bit m_on, m_redir;
  int m_stall, m_flush;
  pipeline_ctrl_if bus ();
  pipeline_ctrl dut (.clk(clk), .arst_n(arst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit src_hit(input logic [4:0] rd);
    return (bus.rs_id != 0 && bus.rs_id == rd) || (bus.uses_rt_id && bus.rt_id != 0 && bus.rt_id == rd);
  endfunction

  function automatic bit m_hazard();
    logic [4:0] rd[3];
    bit we[3];
    bit h = 0;
    rd = '{bus.rd_ex, bus.rd_mem, bus.rd_wb};
    we = '{bus.regwrite_ex, bus.regwrite_mem, bus.regwrite_wb};
`ifdef PIPELINE_CTRL_FORWARDING_EN
    return bus.memread_ex && we[0] && src_hit(rd[0]);
`else
    foreach (rd[i]) if (we[i] && src_hit(rd[i])) h = 1;
    return h;
`endif
  endfunction

  // {pc_en, if_id_en, pipe_en, if_id_flush, id_ex_flush, ex_mem_flush}
  function automatic logic [5:0] m_outs();
    bit redir = (bus.branch_mem && bus.zero_mem) || bus.jump_mem;
    if (!arst_n || !bus.enable) return 6'b000000;
    if (!m_on) return 6'b111000;
    if (m_redir) return 6'b111100;
    if (redir) return 6'b111111;
    if (m_hazard()) return 6'b001010;
    return 6'b111000;
  endfunction

  function automatic logic [5:0] dut_outs();
    return {bus.pc_en, bus.if_id_en, bus.pipe_en, bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
  endfunction

  task automatic m_advance();
    bit redir = (bus.branch_mem && bus.zero_mem) || bus.jump_mem;
    if (!bus.enable) begin m_on = 0; m_redir = 0; end
    else if (!m_on) m_on = 1;
    else if (m_redir) m_redir = 0;
    else if (redir) begin m_redir = 1; if (m_flush < 65535) m_flush++; end
    else if (m_hazard()) begin if (m_stall < 65535) m_stall++; end
  endtask

  task automatic step(input string tag);
    #1 chk({tag, ".outs"}, 32'(dut_outs()), 32'(m_outs()));
    @(posedge clk);
    m_advance();
    @(negedge clk);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_on));
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(m_flush));
  endtask

  task automatic clear_in();
    {bus.rs_id, bus.rt_id, bus.rd_ex, bus.rd_mem, bus.rd_wb} = '0;
    {bus.uses_rt_id, bus.memread_ex, bus.regwrite_ex, bus.regwrite_mem, bus.regwrite_wb} = '0;
    {bus.branch_mem, bus.zero_mem, bus.jump_mem} = '0;
  endtask

  task automatic do_reset(input string tag);
    arst_n = 1'b0;
    #1 chk({tag, ".rst_outs"}, 32'(dut_outs()), 32'd0);
    chk({tag, ".rst_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".rst_stall"}, 32'(bus.stall_cnt), 32'd0);
    chk({tag, ".rst_flush"}, 32'(bus.flush_cnt), 32'd0);
    m_on = 0; m_redir = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    bus.enable = 1'b0;
    clear_in();
    do_reset("por");
    bus.enable = 1'b1;
    step("start");
    chk("start.pc_en", 32'(bus.pc_en), 32'd1);
    chk("start.busy_const", 32'(bus.busy), 32'd1);
    step("run");
    bus.memread_ex = 1; bus.regwrite_ex = 1; bus.rd_ex = 5; bus.rs_id = 5;
    #1 chk("loaduse.pc_en", 32'(bus.pc_en), 32'd0);
    chk("loaduse.id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
    step("loaduse");
    chk("loaduse.stall1", 32'(bus.stall_cnt), 32'd1);
    clear_in();
    step("loaduse_done");
    bus.memread_ex = 1; bus.regwrite_ex = 1;
    step("r0_nostall");
    chk("r0.stall_same", 32'(bus.stall_cnt), 32'd1);
    clear_in();
    do_reset("rst2");
    bus.enable = 1'b1;
    step("start2");
    bus.memread_ex = 1; bus.regwrite_ex = 1; bus.rd_ex = 7; bus.rs_id = 7;
    bus.branch_mem = 1; bus.zero_mem = 1;
    #1 chk("redir.flushes", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}), 32'b111);
    step("redir");
    step("redir_flushstate");
    chk("redir.flush1", 32'(bus.flush_cnt), 32'd1);
    chk("redir.stall0", 32'(bus.stall_cnt), 32'd0);
    clear_in();
    step("after_redir");
    do_reset("rst3");
    bus.enable = 1'b1;
    step("start3");
    bus.regwrite_mem = 1; bus.rd_mem = 3; bus.rt_id = 3; bus.uses_rt_id = 1;
    step("mem_prod");
    bus.regwrite_mem = 0; bus.regwrite_wb = 1; bus.rd_wb = 3;
    step("wb_prod");
    clear_in(); bus.rt_id = 3; bus.uses_rt_id = 1;
    step("prod_gone");
`ifndef PIPELINE_CTRL_FORWARDING_EN
    chk("mem_wb.stall2", 32'(bus.stall_cnt), 32'd2);
`endif
    bus.regwrite_ex = 1; bus.rd_ex = 9; bus.rs_id = 9; bus.memread_ex = 1;
    step("pre_rst_stall");
    #2 arst_n = 1'b0;
    #1 chk("midrst.outs", 32'(dut_outs()), 32'd0);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.stall", 32'(bus.stall_cnt), 32'd0);
    m_on = 0; m_redir = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    arst_n = 1'b1;
    clear_in();
    for (int i = 0; i < 600; i++) begin
      bus.enable = ($urandom_range(0, 15) != 0);
      bus.rs_id = 5'($urandom_range(0, 3));
      bus.rt_id = 5'($urandom_range(0, 3));
      bus.rd_ex = 5'($urandom_range(0, 3));
      bus.rd_mem = 5'($urandom_range(0, 3));
      bus.rd_wb = 5'($urandom_range(0, 3));
      {bus.uses_rt_id, bus.memread_ex, bus.regwrite_ex, bus.regwrite_mem, bus.regwrite_wb} = 5'($urandom);
      bus.branch_mem = ($urandom_range(0, 5) == 0);
      bus.zero_mem = $urandom_range(0, 1) == 1;
      bus.jump_mem = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      else step("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
